pipe_reg_hs: RTL and testbench

- Parametrised multi-stage pipeline register with per-stage enable and valid/ready handshake.
- Next generation of the enable-gated data flip-flop used throughout the CORDIC sine/cosine datapath.
- Adds configurable depth, back-pressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between CORDIC iteration stages and between the datapath and the result interface.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stage.sv | 33 +++
 rtl/pipe_reg_hs.sv | 97 +++++++++
 tb/tb_pipe_reg_hs.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared limits, helpers and elaboration-time parameter checks for the
// handshaked pipeline register family.
`ifndef PIPE_PKG_SV
`define PIPE_PKG_SV

// Expands to generate-time checks; an out-of-range value stops elaboration.
`define PIPE_CHECK_PARAMS(W_, DEPTH_) \
    if ((W_) < 1 || (W_) > pipe_pkg::MAX_W) begin : g_bad_w \
        $error("pipe: W=%0d outside 1..%0d", (W_), pipe_pkg::MAX_W); \
    end \
    if ((DEPTH_) < 1 || (DEPTH_) > pipe_pkg::MAX_DEPTH) begin : g_bad_depth \
        $error("pipe: DEPTH=%0d outside 1..%0d", (DEPTH_), pipe_pkg::MAX_DEPTH); \
    end

`endif

package pipe_pkg;

    localparam int MAX_DEPTH = 16;
    localparam int MAX_W     = 128;

    // Ceiling log2, never narrower than one bit so counters stay legal.
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus an enable-gated data register that
// only captures when a valid item is loaded, so bubbles never toggle data.
module pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         vin,
    input  logic [W-1:0] din,
    output logic         vout,
    output logic [W-1:0] dout
);

    logic         v_q;
    logic [W-1:0] d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (load) begin
            v_q <= vin;
            if (vin) begin
                d_q <= din;
            end
        end
    end

    assign vout = v_q;
    assign dout = d_q;

endmodule

// File: rtl/pipe_reg_hs.sv
// Multi-stage valid/ready pipeline register with bubble collapsing,
// synchronous flush and an occupancy count.
module pipe_reg_hs
    import pipe_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 3,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] occupancy
);

    `PIPE_CHECK_PARAMS(W, DEPTH)

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] vin;
    logic [W-1:0]     d   [DEPTH];
    logic [W-1:0]     din [DEPTH];
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_d;
    logic             in_hs;
    logic             out_hs;

    // A stage may move when any stage from it to the output is empty or the
    // sink is ready; the out_ready -> in_ready path is purely combinational.
    always_comb begin
        logic tail_full;
        mv        = '0;
        tail_full = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            tail_full = tail_full && v[i];
            mv[i]     = out_ready || !tail_full;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign vin[i] = in_valid && !clr;
            assign din[i] = in_data;
        end else begin : g_body
            assign vin[i] = v[i-1] && !clr;
            assign din[i] = d[i-1];
        end

        // Flush forces a load of an invalid item, which clears v and holds d.
        assign load[i] = mv[i] || clr;

        pipe_stage #(
            .W(W)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .load (load[i]),
            .vin  (vin[i]),
            .din  (din[i]),
            .vout (v[i]),
            .dout (d[i])
        );
    end

    assign in_ready  = mv[0] && !clr;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CW'(in_hs) - CW'(out_hs);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Scoreboard bench: a DEPTH=3 and a DEPTH=1 instance share stimulus; each
// has its own expected-data queue and occupancy/readiness model.
module tb_pipe_reg_hs;
    import pipe_pkg::*;

    localparam int W   = 32;
    localparam int CW3 = clog2(3 + 1);
    localparam int CW1 = clog2(1 + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           out_ready;

    logic           in_ready3, out_valid3, in_ready1, out_valid1;
    logic [W-1:0]   out_data3, out_data1;
    logic [CW3-1:0] occ3;
    logic [CW1-1:0] occ1;

    logic [W-1:0] q3[$];
    logic [W-1:0] q1[$];
    int           n_chk = 0;
    int           n_err = 0;
    int           cnt3 = 0;
    int           cnt1 = 0;
    int           c0;
    bit           evt3 = 1'b1, evt1 = 1'b1;

    always #5 clk = ~clk;

    pipe_reg_hs #(.W(W), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .occupancy(occ3)
    );

    pipe_reg_hs #(.W(W), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] dat);
        int n = 0;
        in_valid = 1'b1;
        in_data  = dat;
        @(negedge clk);
        while (!in_ready3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready3), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((occ3 != 0 || occ1 != 0) && n < 40) begin
            tick();
            n++;
        end
        chk("drain3", 32'(occ3), 0);
        chk("drain1", 32'(occ1), 0);
    endtask

    // DEPTH=3 monitor: occupancy, readiness, stall stability, data order.
    initial forever begin
        logic         pv, pr, pc;
        logic [W-1:0] pd;
        @(negedge clk);
        if (!rst) begin
            chk("occ3", 32'(occ3), 32'(q3.size()));
            chk("rdy3", 32'(in_ready3), 32'(!clr && (q3.size() < 3 || out_ready)));
            if (!evt3 && pv && !pr && !pc) begin
                chk("stall_v3", 32'(out_valid3), 1);
                chk("stall_d3", out_data3, pd);
            end
            if (out_valid3 && out_ready) begin
                cnt3++;
                if (q3.size() == 0) chk("extra3", 32'(out_valid3), 0);
                else chk("data3", out_data3, q3.pop_front());
            end
            if (in_valid && in_ready3) q3.push_back(in_data);
            if (clr) q3.delete();
            pv = out_valid3; pr = out_ready; pc = clr; pd = out_data3;
            evt3 = 1'b0;
        end
    end

    // DEPTH=1 monitor.
    initial forever begin
        logic         pv, pr, pc;
        logic [W-1:0] pd;
        @(negedge clk);
        if (!rst) begin
            chk("occ1", 32'(occ1), 32'(q1.size()));
            chk("rdy1", 32'(in_ready1), 32'(!clr && (q1.size() < 1 || out_ready)));
            if (!evt1 && pv && !pr && !pc) begin
                chk("stall_v1", 32'(out_valid1), 1);
                chk("stall_d1", out_data1, pd);
            end
            if (out_valid1 && out_ready) begin
                cnt1++;
                if (q1.size() == 0) chk("extra1", 32'(out_valid1), 0);
                else chk("data1", out_data1, q1.pop_front());
            end
            if (in_valid && in_ready1) q1.push_back(in_data);
            if (clr) q1.delete();
            pv = out_valid1; pr = out_ready; pc = clr; pd = out_data1;
            evt1 = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        rst = 1'b0;
        #1;
        chk("rst_ov3", 32'(out_valid3), 0);
        chk("rst_od3", out_data3, 0);
        chk("rst_occ3", 32'(occ3), 0);
        chk("rst_rdy3", 32'(in_ready3), 1);
        chk("rst_ov1", 32'(out_valid1), 0);
        tick();

        // Reset in the middle of a stream
        send(32'h77);
        send(32'h78);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_ov3", 32'(out_valid3), 0);
        chk("mid_od3", out_data3, 0);
        chk("mid_occ3", 32'(occ3), 0);
        chk("mid_ov1", 32'(out_valid1), 0);
        chk("mid_od1", out_data1, 0);
        chk("mid_occ1", 32'(occ1), 0);
        rst = 1'b0;
        q3.delete(); q1.delete();
        evt3 = 1'b1; evt1 = 1'b1;
        #1;
        chk("mid_rdy3", 32'(in_ready3), 1);
        chk("mid_rdy1", 32'(in_ready1), 1);
        tick();

        // Streaming with latency and steady occupancy
        out_ready = 1'b1;
        c0 = cnt3;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            tick();
            chk("latency", 32'(out_valid3), 32'(k >= 3));
            if (k >= 3) chk("occ_stream", 32'(occ3), 3);
        end
        drain();
        chk("stream_cnt", 32'(cnt3 - c0), 8);

        // Back-pressure: fourth item waits while full
        out_ready = 1'b0;
        c0 = cnt3;
        send(32'hA); send(32'hB); send(32'hC);
        in_valid = 1'b1;
        in_data  = 32'hD;
        for (int k = 0; k < 3; k++) begin
            chk("bp_rdy", 32'(in_ready3), 0);
            chk("bp_occ", 32'(occ3), 3);
            chk("bp_od", out_data3, 32'hA);
            chk("bp_ov", 32'(out_valid3), 1);
            tick();
        end
        out_ready = 1'b1;
        send(32'hD);
        drain();
        chk("bp_cnt", 32'(cnt3 - c0), 4);

        // Bubble collapse under stall
        out_ready = 1'b0;
        send(32'h11);
        tick(); tick();
        send(32'h22);
        tick(); tick(); tick();
        chk("bub_occ", 32'(occ3), 2);
        chk("bub_out", out_data3, 32'h11);
        chk("bub_s1d", dut3.g_stage[1].u_stage.dout, 32'h22);
        chk("bub_s1v", 32'(dut3.g_stage[1].u_stage.vout), 1);
        chk("bub_s0v", 32'(dut3.g_stage[0].u_stage.vout), 0);

        // Flush beats a concurrent input
        send(32'h33);
        chk("fl_full", 32'(occ3), 3);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h55;
        #1;
        chk("fl_rdy3", 32'(in_ready3), 0);
        chk("fl_rdy1", 32'(in_ready1), 0);
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ3", 32'(occ3), 0);
        chk("fl_ov3", 32'(out_valid3), 0);
        chk("fl_occ1", 32'(occ1), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("fl_no55", 32'(out_valid3), 0);

        // Simultaneous in/out at full, both depths
        out_ready = 1'b0;
        send(32'h201); send(32'h202); send(32'h203);
        out_ready = 1'b1;
        c0 = cnt3;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + 32'(k);
            tick();
            chk("sim_occ3", 32'(occ3), 3);
            chk("sim_occ1", 32'(occ1), 1);
            chk("sim_rdy3", 32'(in_ready3), 1);
            chk("sim_rdy1", 32'(in_ready1), 1);
        end
        in_valid = 1'b0;
        chk("sim_cnt", 32'(cnt3 - c0), 6);
        drain();
        tick();
        chk("q3_empty", 32'(q3.size()), 0);
        chk("q1_empty", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
